// File: rtl/priority_scan_serializer.sv
// Purpose : accepts an N-bit request vector and emits the index of each set bit,
//           highest (MSB_FIRST=1) or lowest (MSB_FIRST=0) index first.
// Latency : first index is valid 1 cycle after accept; one index per cycle while out_ready=1.
// Backpress: in_ready=0 while scanning; out_ready=0 holds y/valid/pending unchanged.
// Ports   : clk, rst (async, active high); a/in_valid/in_ready = vector input handshake;
//           y/valid/out_ready = index output handshake; none = pulse after an all-zero accept;
//           last (only with PRIO_SCAN_LAST_EN defined) = current index is the final set bit.
module priority_scan_serializer #(
  parameter int N         = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         a,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [$clog2(N)-1:0] y,
  output logic                 valid,
  input  logic                 out_ready,
  output logic                 none
`ifdef PRIO_SCAN_LAST_EN
  ,
  output logic                 last
`endif
);

  localparam int W = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic           none_q, none_d;

  // Priority encoder over the registered pending vector only, so there is
  // no combinational path from a to y.
  logic [W-1:0]   scan_idx;
  logic [N-1:0]   scan_oh;

  always_comb begin
    scan_idx = '0;
    scan_oh  = '0;
    if (MSB_FIRST != 0) begin
      // Ascending walk: the last hit (highest index) wins.
      for (int i = 0; i < N; i++) begin
        if (pending_q[i]) begin
          scan_idx   = W'(i);
          scan_oh    = '0;
          scan_oh[i] = 1'b1;
        end
      end
    end else begin
      // Descending walk: the last hit (lowest index) wins.
      for (int i = N - 1; i >= 0; i--) begin
        if (pending_q[i]) begin
          scan_idx   = W'(i);
          scan_oh    = '0;
          scan_oh[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    none_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (a != '0) begin
            pending_d = a;
            state_d   = SCAN;
          end else begin
            none_d    = 1'b1;
          end
        end
      end
      SCAN: begin
        if (out_ready) begin
          pending_d = pending_q & ~scan_oh;
          // Leave on the same edge that consumes the final bit.
          if ((pending_q & ~scan_oh) == '0) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      none_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      none_q    <= none_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign valid    = (state_q == SCAN);
  assign y        = valid ? scan_idx : '0;
  assign none     = none_q;

`ifdef PRIO_SCAN_LAST_EN
  // Final index when nothing else remains once the current bit is removed.
  assign last = valid && ((pending_q & ~scan_oh) == '0);
`endif

endmodule
